// File: rtl/uart_transmit_fifo.sv
// 8N1 UART transmitter with a byte FIFO in front of the line-timing state machine.
// tx_wire_out is registered from the current state, so the start bit appears one edge after the pop.
module uart_transmit_fifo #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    data_byte_in,
  input  logic                          trigger_in,
  output logic                          ready_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          tx_wire_out
);

  localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int BW     = $clog2(PERIOD + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   baud_cnt, baud_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, line, baud_done, fifo_empty;

  assign fifo_empty     = (count == '0);
  assign ready_out      = (count != CW'(FIFO_DEPTH));
  assign push           = trigger_in && ready_out;
  assign baud_done      = (baud_cnt == BW'(PERIOD - 1));
  assign busy_out       = (state != IDLE) || !fifo_empty;
  assign fifo_count_out = count;

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + BW'(1);
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    pop       = 1'b0;
    line      = 1'b1;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
        end
      end
      START: begin
        line = 1'b0;
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        line = shift[0];
        if (baud_done) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push) mem[wr_ptr] <= data_byte_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tx_wire_out <= 1'b1;
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      shift       <= shift_nxt;
      tx_wire_out <= line;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmit_fifo.sv
// Bench for uart_transmit_fifo: frame-level queue model checked every cycle,
// an independent mid-bit line decoder, and directed scenarios with literal expectations.
module tb_uart_transmit_fifo;
  localparam int P     = 10;
  localparam int DEPTH = 4;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_byte_in;
  logic       trigger_in;
  logic       ready_out, busy_out, tx_wire_out;
  logic [2:0] fifo_count_out;

  int checks = 0;
  int errors = 0;

  uart_transmit_fifo #(.INPUT_CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_byte_in(data_byte_in), .trigger_in(trigger_in),
    .ready_out(ready_out), .busy_out(busy_out), .fifo_count_out(fifo_count_out),
    .tx_wire_out(tx_wire_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a queue of waiting bytes plus the position within the current frame.
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_active = 0;
  int         m_t      = 0;
  bit         m_valid  = 0;
  logic       m_tx     = 1'b1;
  bit         rx_abort = 0;

  always @(posedge clk_in) begin
    int   pre_size, pos;
    bit   do_push;
    logic ln;
    if (rst_in) begin
      mq.delete();
      m_active = 0;
      m_t      = 0;
      m_tx     = 1'b1;
      m_valid  = 1;
      rx_abort = 1;
    end else if (m_valid) begin
      pre_size = mq.size();
      pos      = m_t / P;
      if (!m_active)   ln = 1'b1;
      else if (pos == 0) ln = 1'b0;
      else if (pos == 9) ln = 1'b1;
      else             ln = m_cur[pos-1];
      do_push = trigger_in && (pre_size < DEPTH);
      if (!m_active) begin
        if (pre_size > 0) begin m_cur = mq.pop_front(); m_active = 1; m_t = 0; end
      end else if (m_t == 10*P - 1) begin
        if (pre_size > 0) begin m_cur = mq.pop_front(); m_t = 0; end
        else m_active = 0;
      end else begin
        m_t++;
      end
      if (do_push) mq.push_back(data_byte_in);
      m_tx = ln;
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      chk("tx_wire",  tx_wire_out,    m_tx);
      chk("busy",     busy_out,       m_active || (mq.size() != 0));
      chk("count",    fifo_count_out, mq.size());
      chk("ready",    ready_out,      mq.size() != DEPTH);
    end
  end

  // Independent line decoder sampling each bit at its midpoint.
  logic [7:0] rx_q[$];
  logic [7:0] ex_q[$];
  bit         rx_act  = 0;
  int         rx_cnt  = 0;
  logic       rx_prev = 1'b1;
  logic [7:0] rx_sh;

  always @(negedge clk_in) begin
    int k;
    if (rx_abort) begin
      rx_abort = 0;
      rx_act   = 0;
      rx_prev  = 1'b1;
    end else begin
      if (!rx_act) begin
        if (rx_prev && !tx_wire_out) begin rx_act = 1; rx_cnt = 0; end
      end else begin
        rx_cnt++;
      end
      if (rx_act && (rx_cnt % P) == P/2) begin
        k = rx_cnt / P;
        if (k == 0) chk("rx_start_bit", tx_wire_out, 1'b0);
        else if (k <= 8) rx_sh[k-1] = tx_wire_out;
        else begin
          chk("rx_stop_bit", tx_wire_out, 1'b1);
          rx_q.push_back(rx_sh);
          rx_act = 0;
        end
      end
      rx_prev = tx_wire_out;
    end
  end

  logic [7:0] wq[$];
  int         cnt_log[$];

  task automatic write_bytes();
    cnt_log.delete();
    foreach (wq[i]) begin
      data_byte_in = wq[i];
      trigger_in   = 1'b1;
      @(negedge clk_in);
      cnt_log.push_back(fifo_count_out);
    end
    trigger_in = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_out && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_pop_next();
    int g = 0;
    while (!(m_active && m_t == 10*P - 1 && mq.size() > 0) && g < 2000) begin
      @(negedge clk_in);
      g++;
    end
    if (g >= 2000) chk("pop_wait_timeout", 1, 0);
  endtask

  task automatic check_rx(input string name);
    chk({name, "_frames"}, rx_q.size(), ex_q.size());
    if (rx_q.size() == ex_q.size())
      foreach (ex_q[i]) chk({name, "_byte"}, rx_q[i], ex_q[i]);
  endtask

  initial begin
    int n;
    rst_in = 1'b1; trigger_in = 1'b0; data_byte_in = 8'h00;
    repeat (2) @(negedge clk_in);
    chk("reset_tx",    tx_wire_out,    1'b1);
    chk("reset_busy",  busy_out,       1'b0);
    chk("reset_count", fifo_count_out, 3'd0);
    chk("reset_ready", ready_out,      1'b1);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // 1: single byte from idle
    rx_q.delete();
    wq = '{8'h55};
    write_bytes();
    @(negedge clk_in); chk("t1_line_before_start", tx_wire_out, 1'b1);
    @(negedge clk_in); chk("t1_start_bit",         tx_wire_out, 1'b0);
    wait_idle(n);      chk("t1_busy_len", n, 99);
    repeat (20) @(negedge clk_in);
    ex_q = '{8'h55}; check_rx("t1_rx");

    // 2: two bytes back-to-back
    rx_q.delete();
    wq = '{8'hA5, 8'h3C};
    write_bytes();
    wait_idle(n); chk("t2_busy_len", n, 200);
    repeat (20) @(negedge clk_in);
    ex_q = '{8'hA5, 8'h3C}; check_rx("t2_rx");

    // 3: overflow burst
    rx_q.delete();
    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    write_bytes();
    chk("t3_cnt0", cnt_log[0], 1);
    chk("t3_cnt1", cnt_log[1], 1);
    chk("t3_cnt2", cnt_log[2], 2);
    chk("t3_cnt3", cnt_log[3], 3);
    chk("t3_cnt4", cnt_log[4], 4);
    chk("t3_cnt5", cnt_log[5], 4);
    chk("t3_ready_low", ready_out, 1'b0);
    wait_idle(n); chk("t3_busy_len", n, 496);
    repeat (20) @(negedge clk_in);
    ex_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; check_rx("t3_rx");

    // 4: reset mid-frame with two bytes queued; trigger during reset is ignored
    rx_q.delete();
    wq = '{8'h10, 8'h20, 8'h30};
    write_bytes();
    chk("t4_queued", fifo_count_out, 3'd2);
    repeat (34) @(negedge clk_in);
    rst_in = 1'b1; trigger_in = 1'b1; data_byte_in = 8'h77;
    @(negedge clk_in);
    rst_in = 1'b0; trigger_in = 1'b0;
    chk("t4_tx_high", tx_wire_out,    1'b1);
    chk("t4_busy",    busy_out,       1'b0);
    chk("t4_count",   fifo_count_out, 3'd0);
    repeat (300) @(negedge clk_in);
    chk("t4_still_idle", busy_out, 1'b0);
    ex_q.delete(); check_rx("t4_rx");

    // 5: write while full at a pop, then push and pop together
    rx_q.delete();
    wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    write_bytes();
    chk("t5_full", fifo_count_out, 3'd4);
    wait_pop_next();
    data_byte_in = 8'hEE; trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("t5_drop_count", fifo_count_out, 3'd3);
    wait_pop_next();
    chk("t5_ready_before", ready_out, 1'b1);
    data_byte_in = 8'h42; trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("t5_push_pop_count", fifo_count_out, 3'd3);
    wait_idle(n);
    repeat (20) @(negedge clk_in);
    ex_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h42}; check_rx("t5_rx");

    // 6: loopback-style decode of edge-case bytes
    rx_q.delete();
    wq = '{8'h00, 8'hFF, 8'h81};
    write_bytes();
    wait_idle(n); chk("t6_busy_len", n, 299);
    repeat (20) @(negedge clk_in);
    ex_q = '{8'h00, 8'hFF, 8'h81}; check_rx("t6_rx");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
